// File: rtl/key_expansion_controller.sv
// AES-128 key schedule sequencer: walks W0..W3 through 11 round keys using an
// external SubWord S-box, handing each round key to a valid/ready consumer.
module key_expansion_controller #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] Key,
  output logic [31:0]  sub_word_in,
  input  logic [31:0]  sub_word_out,
  output logic [127:0] Round_Key,
  output logic [3:0]   Round_Num,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_SUB,
    S_EXPAND,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t      state, state_nx;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [3:0]  round;
  logic [7:0]  rcon;
  logic [31:0] w0_nx, w1_nx, w2_nx, w3_nx;
  logic        xfer;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  assign sub_word_in = {w3[23:0], w3[31:24]};
  assign Round_Key   = {w0, w1, w2, w3};
  assign Round_Num   = round;
  assign key_valid   = (state == S_EMIT);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign xfer        = key_valid & key_ready;

  // Each new word chains off the freshly computed previous word.
  always_comb begin
    w0_nx = w0 ^ temp;
    w1_nx = w1 ^ w0_nx;
    w2_nx = w2 ^ w1_nx;
    w3_nx = w3 ^ w2_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_EMIT;
      S_EMIT:   if (xfer) state_nx = (round == LAST_ROUND) ? S_DONE : S_SUB;
      S_SUB:    state_nx = S_EXPAND;
      S_EXPAND: state_nx = S_EMIT;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
      temp  <= '0;
      round <= '0;
      rcon  <= 8'h01;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            w0    <= Key[127:96];
            w1    <= Key[95:64];
            w2    <= Key[63:32];
            w3    <= Key[31:0];
            round <= '0;
            rcon  <= 8'h01;
          end
        end
        S_SUB: begin
          temp <= sub_word_out ^ {rcon, 24'h0};
        end
        S_EXPAND: begin
          w0    <= w0_nx;
          w1    <= w1_nx;
          w2    <= w2_nx;
          w3    <= w3_nx;
          round <= round + 4'd1;
          rcon  <= xtime(rcon);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expansion_controller.sv
// Bench for key_expansion_controller: S-box and FIPS-197 key schedule are
// recomputed here from first principles and compared against each handshake.
module tb_key_expansion_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] Key;
  logic [31:0]  sub_word_in;
  logic [31:0]  sub_word_out;
  logic [127:0] Round_Key;
  logic [3:0]   Round_Num;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox   [0:255];
  logic [127:0] expk   [0:10];
  logic [127:0] caught [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  key_expansion_controller #(.NR(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Key          (Key),
    .sub_word_in  (sub_word_in),
    .sub_word_out (sub_word_out),
    .Round_Key    (Round_Key),
    .Round_Num    (Round_Num),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  assign sub_word_out = {sbox[sub_word_in[31:24]], sbox[sub_word_in[23:16]],
                         sbox[sub_word_in[15:8]],  sbox[sub_word_in[7:0]]};

  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    gmul = p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    rotl8 = (a << n) | (a >> (8 - n));
  endfunction

  // S-box = affine transform of the GF(2^8) multiplicative inverse.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    subw = {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) expk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 128'(key_valid), 128'(1'b0));
    chk({tag, "_busy"},  128'(busy),      128'(1'b0));
    chk({tag, "_done"},  128'(done),      128'(1'b0));
    chk({tag, "_key"},   Round_Key,       128'h0);
    chk({tag, "_num"},   128'(Round_Num), 128'(4'd0));
  endtask

  // One full expansion from IDLE; checks every offered key and the done pulse.
  task automatic run_exp(input logic [127:0] key, input bit rnd_ready,
                         input bit noise, input bit lat);
    int cyc = 0;
    int got = 0;
    int idx;
    bit fin = 1'b0;
    expand(key);
    Key   = key;
    start = 1'b1;
    while (!fin && cyc < 800) begin
      tick();
      cyc++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) Key = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (key_valid) begin
        idx = (got > 10) ? 10 : got;
        chk("round_num", 128'(Round_Num), 128'(got));
        chk("round_key", Round_Key, expk[idx]);
        chk("sub_word_in", 128'(sub_word_in),
            128'({Round_Key[23:0], Round_Key[31:24]}));
        if (lat) chk("key_latency", 128'(cyc), 128'(1 + 3*got));
        if (key_ready) begin
          caught[idx] = Round_Key;
          got++;
        end
      end
      if (done) begin
        chk("keys_transferred", 128'(got), 128'(11));
        chk("busy_in_done", 128'(busy), 128'(1'b1));
        if (lat) chk("done_latency", 128'(cyc), 128'(32));
        fin   = 1'b1;
        start = 1'b0;
      end
    end
    chk("expansion_finished", 128'(fin), 128'(1'b1));
    tick();
    chk("idle_busy",  128'(busy),      128'(1'b0));
    chk("idle_valid", 128'(key_valid), 128'(1'b0));
    chk("done_pulse", 128'(done),      128'(1'b0));
    chk("idle_num",   128'(Round_Num), 128'(4'd10));
    chk("idle_key",   Round_Key,       expk[10]);
  endtask

  initial begin
    int wait_cyc;
    logic [127:0] k;

    build_sbox();
    rst       = 1'b1;
    start     = 1'b0;
    Key       = '0;
    key_ready = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #1 chk_all_zero("reset");
    tick();
    tick();
    chk_all_zero("reset_held");
    rst = 1'b1;
    tick();
    chk("idle_no_start", 128'(busy), 128'(1'b0));

    // FIPS-197 key, consumer always ready
    run_exp(FIPS_KEY, 1'b0, 1'b0, 1'b1);
    chk("fips_r0",  caught[0],  FIPS_KEY);
    chk("fips_r1",  caught[1],  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    chk("fips_r10", caught[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    // Same key with back-pressure
    run_exp(FIPS_KEY, 1'b1, 1'b0, 1'b0);
    chk("stall_r10", caught[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    // Random keys, random ready, start and Key wiggling mid-expansion
    for (int n = 0; n < 3; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_exp(k, 1'b1, 1'b1, 1'b0);
      repeat (2) begin
        key_ready = 1'($urandom_range(0, 1));
        tick();
        chk("idle_ready_ignored", 128'(busy), 128'(1'b0));
      end
    end

    // Reset during the SUB cycle that produces round 5
    key_ready = 1'b1;
    Key       = FIPS_KEY;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    chk("pre_abort_valid", 128'(key_valid), 128'(1'b0));
    chk("pre_abort_num",   128'(Round_Num), 128'(4'd4));
    #2 rst = 1'b0;
    #1 chk_all_zero("abort");
    repeat (3) begin
      tick();
      chk_all_zero("abort_held");
    end
    rst = 1'b1;
    tick();
    chk_all_zero("after_abort");
    run_exp(128'h0, 1'b0, 1'b0, 1'b1);
    chk("zero_key_r1", caught[1], 128'h62636363_62636363_62636363_62636363);

    // start held high: back-to-back expansions with one IDLE cycle between
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    Key       = k;
    start     = 1'b1;
    key_ready = 1'b1;
    wait_cyc  = 0;
    do begin
      tick();
      wait_cyc++;
    end while (!done && wait_cyc < 100);
    chk("b2b_done1", 128'(done), 128'(1'b1));
    tick();
    chk("b2b_gap_busy",  128'(busy),      128'(1'b0));
    chk("b2b_gap_valid", 128'(key_valid), 128'(1'b0));
    tick();
    chk("b2b_restart_valid", 128'(key_valid), 128'(1'b1));
    chk("b2b_restart_num",   128'(Round_Num), 128'(4'd0));
    chk("b2b_restart_key",   Round_Key,       k);
    wait_cyc = 0;
    do begin
      tick();
      wait_cyc++;
    end while (!done && wait_cyc < 100);
    chk("b2b_done2", 128'(done), 128'(1'b1));
    start = 1'b0;
    tick();
    tick();
    chk("b2b_stop_busy", 128'(busy), 128'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
